blur_scheduler: RTL and testbench
=================================

// Module: blur_scheduler
// PURPOSE
//  Sequences the 3x3 Gaussian blur engine across a SIFT scale space: NUM_OCTAVES octaves
//  of NUM_LEVELS images each. Issues one-cycle start pulses to the blur engine and the
//  downsampler, waits for their done pulses, and drives buffer selects for each pass.
//  Sits between the top-level SIFT FSM and the blur/downsample datapaths.
// PARAMETERS
//  NUM_LEVELS      5        images per octave (buffer 0 = octave base); >=2
//  NUM_OCTAVES     3        octaves to process; >=2
//  DS_SRC_LEVEL    2        level buffer downsampled to form the next octave base; <NUM_LEVELS
//  TIMEOUT_CYCLES  65536    max cycles waiting for any done pulse before error
// PORTS
//  clk_in               in   1                      system clock
//  rst_n_in             in   1                      async active-low reset
//  start_in             in   1                      one-cycle pulse: begin full scale-space build
//  abort_in             in   1                      sync abort; return to IDLE
//  blur_start_out       out  1                      one-cycle start pulse to blur engine
//  blur_done_in         in   1                      one-cycle done pulse from blur engine
//  ds_start_out         out  1                      one-cycle start pulse to downsampler
//  ds_done_in           in   1                      one-cycle done pulse from downsampler
//  src_level_out        out  $clog2(NUM_LEVELS)     buffer read by current pass
//  dst_level_out        out  $clog2(NUM_LEVELS)     buffer written by current pass
//  octave_out           out  $clog2(NUM_OCTAVES)    octave of current pass
//  busy_out             out  1                      high from start accept until done/error/abort
//  done_out             out  1                      one-cycle pulse: full build complete
//  error_out            out  1                      one-cycle pulse: timeout
// BEHAVIOUR
//  - Reset (rst_n_in low, async): state IDLE; every output 0; timeout counter 0.
//  - All outputs registered. States: IDLE, BLUR_START, BLUR_WAIT, DS_START, DS_WAIT.
//  - IDLE: start_in high at edge N -> BLUR_START; in cycle N+1 blur_start_out=1,
//    octave_out=0, src_level_out=0, dst_level_out=1, busy_out=1.
//  - BLUR_START (1 cycle) -> BLUR_WAIT; timeout counter cleared on entry to any WAIT.
//  - BLUR_WAIT, blur_done_in at edge M:
//    dst<NUM_LEVELS-1 -> BLUR_START, cycle M+1 src=dst, dst=dst+1 (same octave);
//    dst==NUM_LEVELS-1 and octave<NUM_OCTAVES-1 -> DS_START, cycle M+1 ds_start_out=1,
//      src_level_out=DS_SRC_LEVEL, dst_level_out=0, octave_out unchanged;
//    dst==NUM_LEVELS-1 and last octave -> IDLE; cycle M+1 done_out=1, busy_out=0.
//  - DS_START (1 cycle) -> DS_WAIT. ds_done_in in DS_WAIT at edge M -> octave+1,
//    BLUR_START with src=0, dst=1 in cycle M+1.
//  - Selects/octave stable from the start pulse until the next transition; hold last
//    values in IDLE after done.
//  - Done pulses ignored outside the matching WAIT state (blur_done_in in DS_WAIT etc.).
//  - start_in while busy_out=1 ignored. start_in same cycle as done_out accepted only if
//    already in IDLE (i.e. the cycle after done is issued).
//  - Timeout: counter increments each WAIT cycle; reaching TIMEOUT_CYCLES-1 without the
//    matching done -> IDLE, error_out=1 next cycle, busy_out=0, no done_out.
//  - abort_in high in any non-IDLE state: next cycle IDLE, busy_out=0, no pulses.
//    abort_in wins over simultaneous done pulses. abort_in in IDLE: no effect, and
//    start_in in same cycle as abort_in is dropped.
//  - Reset mid-operation: immediate return to reset values; any in-flight start pulse
//    deasserts asynchronously.
//  - Total per build: NUM_OCTAVES*(NUM_LEVELS-1) blur starts, NUM_OCTAVES-1 ds starts.
// TESTING
//  (NUM_LEVELS=3, NUM_OCTAVES=2, DS_SRC_LEVEL=2, TIMEOUT_CYCLES=64 unless noted)
//  1 start, done replies 10 cycles after each start -> blur (o,s,d)=(0,0,1),(0,1,2); ds
//    (0,2,0); blur (1,0,1),(1,1,2); then one done_out; 4 blur + 1 ds pulses, busy low after.
//  2 blur_done_in driven during DS_WAIT and start_in while busy -> both ignored;
//    sequence identical to test 1.
//  3 no blur_done_in after first start -> error_out exactly 64 cycles after BLUR_WAIT
//    entry; busy_out=0, no done_out; new start_in then runs full build.
//  4 abort_in same cycle as second blur_done_in -> IDLE, no further start pulses.
//  5 rst_n_in low during BLUR_START cycle -> blur_start_out drops immediately,
//    all outputs 0; release and start -> normal build.
//  6 done pulse in same cycle as blur_start_out (zero-latency engine model)
//    -> ignored; scheduler waits for next done pulse.

Source files
------------

// File: rtl/blur_scheduler.sv
// Scale-space pass sequencer: walks NUM_OCTAVES octaves of NUM_LEVELS blurred images,
// handshaking with the blur engine and downsampler and steering buffer selects.
module blur_scheduler #(
    parameter int NUM_LEVELS     = 5,
    parameter int NUM_OCTAVES    = 3,
    parameter int DS_SRC_LEVEL   = 2,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                           clk_in,
    input  logic                           rst_n_in,
    input  logic                           start_in,
    input  logic                           abort_in,
    output logic                           blur_start_out,
    input  logic                           blur_done_in,
    output logic                           ds_start_out,
    input  logic                           ds_done_in,
    output logic [$clog2(NUM_LEVELS)-1:0]  src_level_out,
    output logic [$clog2(NUM_LEVELS)-1:0]  dst_level_out,
    output logic [$clog2(NUM_OCTAVES)-1:0] octave_out,
    output logic                           busy_out,
    output logic                           done_out,
    output logic                           error_out
);

    localparam int LW = $clog2(NUM_LEVELS);
    localparam int OW = $clog2(NUM_OCTAVES);
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [LW-1:0] LAST_LEVEL   = LW'(NUM_LEVELS - 1);
    localparam logic [LW-1:0] DS_SRC       = LW'(DS_SRC_LEVEL);
    localparam logic [OW-1:0] LAST_OCTAVE  = OW'(NUM_OCTAVES - 1);
    localparam logic [TW-1:0] TIMER_LIMIT  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        BLUR_START,
        BLUR_WAIT,
        DS_START,
        DS_WAIT
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;

    // Pulses default low every cycle; abort outranks done pulses and the timeout,
    // and selects/octave simply hold whenever we drop back to IDLE.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state          <= IDLE;
            timer          <= '0;
            blur_start_out <= 1'b0;
            ds_start_out   <= 1'b0;
            src_level_out  <= '0;
            dst_level_out  <= '0;
            octave_out     <= '0;
            busy_out       <= 1'b0;
            done_out       <= 1'b0;
            error_out      <= 1'b0;
        end else begin
            blur_start_out <= 1'b0;
            ds_start_out   <= 1'b0;
            done_out       <= 1'b0;
            error_out      <= 1'b0;

            case (state)
                IDLE: begin
                    if (start_in && !abort_in) begin
                        state          <= BLUR_START;
                        blur_start_out <= 1'b1;
                        octave_out     <= '0;
                        src_level_out  <= '0;
                        dst_level_out  <= LW'(1);
                        busy_out       <= 1'b1;
                    end
                end

                BLUR_START: begin
                    if (abort_in) begin
                        state    <= IDLE;
                        busy_out <= 1'b0;
                    end else begin
                        state <= BLUR_WAIT;
                        timer <= '0;
                    end
                end

                BLUR_WAIT: begin
                    if (abort_in) begin
                        state    <= IDLE;
                        busy_out <= 1'b0;
                    end else if (blur_done_in) begin
                        if (dst_level_out != LAST_LEVEL) begin
                            state          <= BLUR_START;
                            blur_start_out <= 1'b1;
                            src_level_out  <= dst_level_out;
                            dst_level_out  <= dst_level_out + LW'(1);
                        end else if (octave_out != LAST_OCTAVE) begin
                            state         <= DS_START;
                            ds_start_out  <= 1'b1;
                            src_level_out <= DS_SRC;
                            dst_level_out <= '0;
                        end else begin
                            state    <= IDLE;
                            done_out <= 1'b1;
                            busy_out <= 1'b0;
                        end
                    end else if (timer == TIMER_LIMIT) begin
                        state     <= IDLE;
                        error_out <= 1'b1;
                        busy_out  <= 1'b0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end

                DS_START: begin
                    if (abort_in) begin
                        state    <= IDLE;
                        busy_out <= 1'b0;
                    end else begin
                        state <= DS_WAIT;
                        timer <= '0;
                    end
                end

                DS_WAIT: begin
                    if (abort_in) begin
                        state    <= IDLE;
                        busy_out <= 1'b0;
                    end else if (ds_done_in) begin
                        state          <= BLUR_START;
                        blur_start_out <= 1'b1;
                        octave_out     <= octave_out + OW'(1);
                        src_level_out  <= '0;
                        dst_level_out  <= LW'(1);
                    end else if (timer == TIMER_LIMIT) begin
                        state     <= IDLE;
                        error_out <= 1'b1;
                        busy_out  <= 1'b0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end

                default: begin
                    state    <= IDLE;
                    busy_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_blur_scheduler.sv
// Directed bench for blur_scheduler: 3 levels, 2 octaves, downsample from level 2,
// 64-cycle timeout.
module tb_blur_scheduler;

    localparam int NL = 3;
    localparam int NO = 2;
    localparam int DSL = 2;
    localparam int TMO = 64;

    logic       clk_in;
    logic       rst_n_in;
    logic       start_in;
    logic       abort_in;
    logic       blur_start_out;
    logic       blur_done_in;
    logic       ds_start_out;
    logic       ds_done_in;
    logic [1:0] src_level_out;
    logic [1:0] dst_level_out;
    logic [0:0] octave_out;
    logic       busy_out;
    logic       done_out;
    logic       error_out;

    int checks = 0;
    int errors = 0;

    int         n_blur, n_ds, n_done, n_err;
    bit         busy_dropped, build_timed_out;
    logic [4:0] blur_log [8];
    logic [4:0] ds_log   [8];
    logic [4:0] exp_blur [4];

    blur_scheduler #(
        .NUM_LEVELS(NL), .NUM_OCTAVES(NO), .DS_SRC_LEVEL(DSL), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .start_in(start_in), .abort_in(abort_in),
        .blur_start_out(blur_start_out), .blur_done_in(blur_done_in),
        .ds_start_out(ds_start_out), .ds_done_in(ds_done_in),
        .src_level_out(src_level_out), .dst_level_out(dst_level_out),
        .octave_out(octave_out), .busy_out(busy_out), .done_out(done_out),
        .error_out(error_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Runs one build with an engine model answering each start after `latency` cycles;
    // with `stray` set it also injects an out-of-place blur_done and a start while busy.
    task automatic drive_build(input int latency, input bit stray);
        int  cd_blur = 0;
        int  cd_ds = 0;
        bit  finished = 0;
        n_blur = 0; n_ds = 0; n_done = 0; n_err = 0;
        busy_dropped = 0; build_timed_out = 1;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            blur_done_in = 1'b0;
            ds_done_in   = 1'b0;
            start_in     = 1'b0;
            if (cd_blur > 0) begin
                cd_blur--;
                if (cd_blur == 0) blur_done_in = 1'b1;
            end
            if (cd_ds > 0) begin
                cd_ds--;
                if (cd_ds == 0) ds_done_in = 1'b1;
            end
            if (stray && cd_ds == 5) blur_done_in = 1'b1;
            if (stray && cd_blur == 5) start_in = 1'b1;
            if (blur_start_out) begin
                if (n_blur < 8) blur_log[n_blur] = {octave_out, src_level_out, dst_level_out};
                n_blur++;
                cd_blur = latency;
            end
            if (ds_start_out) begin
                if (n_ds < 8) ds_log[n_ds] = {octave_out, src_level_out, dst_level_out};
                n_ds++;
                cd_ds = latency;
            end
            if (!done_out && !error_out && !busy_out) busy_dropped = 1;
            if (done_out) n_done++;
            if (error_out) n_err++;
            if (done_out || error_out) begin
                finished = 1;
                build_timed_out = 0;
            end
            if (finished) break;
            tick();
        end
        blur_done_in = 1'b0;
        ds_done_in   = 1'b0;
        start_in     = 1'b0;
    endtask

    task automatic test_reset();
        #23;
        checks++;
        if ({blur_start_out, ds_start_out, src_level_out, dst_level_out, octave_out,
             busy_out, done_out, error_out} !== 10'd0) begin
            errors++;
            $display("FAIL reset_outputs: got blur=%b ds=%b src=%0d dst=%0d oct=%0d busy=%b done=%b err=%b, expected all 0",
                     blur_start_out, ds_start_out, src_level_out, dst_level_out, octave_out,
                     busy_out, done_out, error_out);
        end
        rst_n_in = 1'b1;
        tick();
    endtask

    task automatic test_full_build(input bit stray, input string tag);
        drive_build(10, stray);
        checks++;
        if (build_timed_out !== 1'b0) begin
            errors++;
            $display("FAIL %s_terminated: build never finished, got timed_out=%b expected 0", tag, build_timed_out);
        end
        checks++;
        if (n_blur !== 4) begin
            errors++;
            $display("FAIL %s_blur_count: got %0d expected 4", tag, n_blur);
        end
        checks++;
        if (n_ds !== 1) begin
            errors++;
            $display("FAIL %s_ds_count: got %0d expected 1", tag, n_ds);
        end
        for (int i = 0; i < 4; i++) begin
            if (i < n_blur) begin
                checks++;
                if (blur_log[i] !== exp_blur[i]) begin
                    errors++;
                    $display("FAIL %s_blur%0d_sel: got o=%0d s=%0d d=%0d expected o=%0d s=%0d d=%0d",
                             tag, i, blur_log[i][4], blur_log[i][3:2], blur_log[i][1:0],
                             exp_blur[i][4], exp_blur[i][3:2], exp_blur[i][1:0]);
                end
            end
        end
        if (n_ds > 0) begin
            checks++;
            if (ds_log[0] !== 5'b0_10_00) begin
                errors++;
                $display("FAIL %s_ds_sel: got o=%0d s=%0d d=%0d expected o=0 s=2 d=0",
                         tag, ds_log[0][4], ds_log[0][3:2], ds_log[0][1:0]);
            end
        end
        checks++;
        if (n_done !== 1 || n_err !== 0) begin
            errors++;
            $display("FAIL %s_done_pulse: got done=%0d err=%0d expected done=1 err=0", tag, n_done, n_err);
        end
        checks++;
        if (busy_out !== 1'b0 || busy_dropped !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy: got busy_at_done=%b dropped_early=%b expected 0 0", tag, busy_out, busy_dropped);
        end
        checks++;
        if ({octave_out, src_level_out, dst_level_out} !== 5'b1_01_10) begin
            errors++;
            $display("FAIL %s_hold_sel: got o=%0d s=%0d d=%0d expected o=1 s=1 d=2",
                     tag, octave_out, src_level_out, dst_level_out);
        end
        tick();
        checks++;
        if (done_out !== 1'b0 || busy_out !== 1'b0 || blur_start_out !== 1'b0) begin
            errors++;
            $display("FAIL %s_after_done: got done=%b busy=%b blur_start=%b expected 0 0 0",
                     tag, done_out, busy_out, blur_start_out);
        end
    endtask

    task automatic test_timeout();
        int t;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        checks++;
        if (blur_start_out !== 1'b1 || busy_out !== 1'b1) begin
            errors++;
            $display("FAIL timeout_first_start: got blur_start=%b busy=%b expected 1 1", blur_start_out, busy_out);
        end
        for (t = 1; t <= 200; t++) begin
            tick();
            if (error_out) break;
        end
        checks++;
        if (t !== TMO + 1) begin
            errors++;
            $display("FAIL timeout_latency: got error %0d cycles after start pulse, expected %0d", t, TMO + 1);
        end
        checks++;
        if (busy_out !== 1'b0 || done_out !== 1'b0) begin
            errors++;
            $display("FAIL timeout_flags: got busy=%b done=%b expected 0 0", busy_out, done_out);
        end
        tick();
        checks++;
        if (error_out !== 1'b0) begin
            errors++;
            $display("FAIL timeout_error_width: got error=%b expected 0", error_out);
        end
        test_full_build(0, "after_timeout");
    endtask

    task automatic test_abort();
        int seen = 0;
        int cd = 0;
        int extra = 0;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        for (int c = 0; c < 400; c++) begin
            blur_done_in = 1'b0;
            abort_in     = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    blur_done_in = 1'b1;
                    if (seen == 2) abort_in = 1'b1;
                end
            end
            if (blur_start_out) begin
                seen++;
                cd = 10;
            end
            if (abort_in) begin
                tick();
                break;
            end
            tick();
        end
        blur_done_in = 1'b0;
        abort_in     = 1'b0;
        checks++;
        if (seen !== 2) begin
            errors++;
            $display("FAIL abort_blur_starts: got %0d expected 2", seen);
        end
        checks++;
        if (busy_out !== 1'b0 || done_out !== 1'b0 || ds_start_out !== 1'b0 || blur_start_out !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: got busy=%b done=%b ds_start=%b blur_start=%b expected 0 0 0 0",
                     busy_out, done_out, ds_start_out, blur_start_out);
        end
        for (int c = 0; c < 40; c++) begin
            tick();
            if (blur_start_out || ds_start_out || done_out || error_out) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL abort_quiet: got %0d pulse cycles expected 0", extra);
        end
        start_in = 1'b1;
        abort_in = 1'b1;
        tick();
        start_in = 1'b0;
        abort_in = 1'b0;
        checks++;
        if (busy_out !== 1'b0 || blur_start_out !== 1'b0) begin
            errors++;
            $display("FAIL abort_drops_start: got busy=%b blur_start=%b expected 0 0", busy_out, blur_start_out);
        end
    endtask

    task automatic test_reset_mid_start();
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        checks++;
        if (blur_start_out !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pulse_seen: got blur_start=%b expected 1", blur_start_out);
        end
        rst_n_in = 1'b0;
        #1;
        checks++;
        if ({blur_start_out, ds_start_out, src_level_out, dst_level_out, octave_out,
             busy_out, done_out, error_out} !== 10'd0) begin
            errors++;
            $display("FAIL midreset_async: got blur=%b busy=%b src=%0d dst=%0d expected all 0",
                     blur_start_out, busy_out, src_level_out, dst_level_out);
        end
        #2;
        rst_n_in = 1'b1;
        tick();
        test_full_build(0, "after_reset");
    endtask

    task automatic test_zero_latency_done();
        int extra = 0;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        blur_done_in = 1'b1;
        tick();
        blur_done_in = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (blur_start_out || done_out || ds_start_out) extra++;
            tick();
        end
        checks++;
        if (extra !== 0 || busy_out !== 1'b1 || dst_level_out !== 2'd1) begin
            errors++;
            $display("FAIL zerolat_ignored: got pulses=%0d busy=%b dst=%0d expected 0 1 1",
                     extra, busy_out, dst_level_out);
        end
        blur_done_in = 1'b1;
        tick();
        blur_done_in = 1'b0;
        checks++;
        if (blur_start_out !== 1'b1 || src_level_out !== 2'd1 || dst_level_out !== 2'd2) begin
            errors++;
            $display("FAIL zerolat_next_pass: got blur_start=%b src=%0d dst=%0d expected 1 1 2",
                     blur_start_out, src_level_out, dst_level_out);
        end
        abort_in = 1'b1;
        tick();
        abort_in = 1'b0;
        checks++;
        if (busy_out !== 1'b0) begin
            errors++;
            $display("FAIL zerolat_cleanup: got busy=%b expected 0", busy_out);
        end
    endtask

    initial begin
        rst_n_in     = 1'b0;
        start_in     = 1'b0;
        abort_in     = 1'b0;
        blur_done_in = 1'b0;
        ds_done_in   = 1'b0;
        exp_blur[0]  = 5'b0_00_01;
        exp_blur[1]  = 5'b0_01_10;
        exp_blur[2]  = 5'b1_00_01;
        exp_blur[3]  = 5'b1_01_10;

        test_reset();
        test_full_build(0, "basic");
        test_full_build(1, "back_to_back_stray");
        test_timeout();
        test_abort();
        test_reset_mid_start();
        test_zero_latency_done();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
